// File: rtl/fp_pkg.sv
// fp_pkg: shared FP32 field widths, saturation constants and converter state encoding
package fp_pkg;
   localparam int EXP_W = 8;
   localparam int FRAC_W = 23;
   localparam int BIAS = 127;
   localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
   localparam logic [31:0] INT_MAX = 32'h7FFFFFFF;
   localparam logic [31:0] INT_MIN = 32'h80000000;
   typedef enum logic [1:0] {IDLE, UNPACK, SHIFT, PACK} state_t;
endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: combinational FP32 classifier and shift planner (FP2INT_ROUND_NEAREST_EN widens the shift range to E=-1)
module fp_unpack #(
   parameter int BIAS = fp_pkg::BIAS
) (
   input  logic [31:0] a,
   output logic        s,
   output logic [23:0] mant,
   output logic        is_nan,
   output logic        is_inf,
   output logic        is_zero_or_small,
   output logic        is_ovf,
   output logic        is_min,
   output logic        shl,
   output logic [4:0]  shift_n
);
   import fp_pkg::*;
   logic [EXP_W-1:0]  e;
   logic [FRAC_W-1:0] f;
   assign {s, e, f} = a;
   assign mant = {e != '0, f};
   assign is_nan = e == EXP_SPECIAL && f != '0;
   assign is_inf = e == EXP_SPECIAL && f == '0;
   // exactly -2^31 is the only representable value with E=31
   assign is_min = s && e == 8'(BIAS + 31) && f == '0;
   assign is_ovf = e != EXP_SPECIAL && e >= 8'(BIAS + 31) && !is_min;
`ifdef FP2INT_ROUND_NEAREST_EN
   assign is_zero_or_small = e < 8'(BIAS - 1);
`else
   assign is_zero_or_small = e < 8'(BIAS);
`endif
   assign shl = e >= 8'(BIAS + 23);
   // counts stay within 0..24, so 5-bit modular arithmetic is exact
   assign shift_n = shl ? 5'(e - 8'(BIAS + 23)) : 5'(8'(BIAS + 23) - e);
endmodule

// File: rtl/fp_to_int_converter.sv
// fp_to_int_converter: multi-cycle FP32 to int32 converter (FP2INT_ROUND_NEAREST_EN selects round-half-even)
module fp_to_int_converter #(
   parameter int INT_W = 32,
   parameter int BIAS = fp_pkg::BIAS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        NAN,
   output logic        INF,
   output logic        NEG_INF,
   output logic        ERR
);
   import fp_pkg::*;
   state_t             state_q, state_d;
   logic [31:0]        a_q, a_d;
   logic [INT_W-1:0]   acc_q, acc_d, result_q, result_d, mag;
   logic [4:0]         cnt_q, cnt_d;
   logic               shl_q, shl_d, s_q, s_d, fix_q, fix_d, busy_q, busy_d, done_q, done_d;
   logic [3:0]         flg_q, flg_d, out_q, out_d;
   logic               inc;
   logic               u_s, u_nan, u_inf, u_small, u_ovf, u_min, u_shl;
   logic [23:0]        u_mant;
   logic [4:0]         u_n;
   fp_unpack #(.BIAS(BIAS)) u_unpack (
      .a(a_q), .s(u_s), .mant(u_mant), .is_nan(u_nan), .is_inf(u_inf),
      .is_zero_or_small(u_small), .is_ovf(u_ovf), .is_min(u_min),
      .shl(u_shl), .shift_n(u_n)
   );
`ifdef FP2INT_ROUND_NEAREST_EN
   logic grd_q, grd_d, stk_q, stk_d;
   assign inc = grd_q & (stk_q | acc_q[0]);
   // guard/sticky capture the bits discarded by right shifts
   always_comb begin
      grd_d = grd_q;
      stk_d = stk_q;
      if (state_q == UNPACK) begin
         grd_d = 1'b0;
         stk_d = 1'b0;
      end else if (state_q == SHIFT && !shl_q) begin
         grd_d = acc_q[0];
         stk_d = stk_q | grd_q;
      end
   end
   // guard/sticky registers
   always_ff @(posedge clk) begin
      grd_q <= rst ? 1'b0 : grd_d;
      stk_q <= rst ? 1'b0 : stk_d;
   end
`else
   assign inc = 1'b0;
`endif
   assign mag = acc_q + INT_W'(inc);
   assign busy = busy_q;
   assign done = done_q;
   assign result = result_q;
   assign {NAN, INF, NEG_INF, ERR} = out_q;
   // sequencing: accept, classify, align one bit per cycle, then negate and publish
   always_comb begin
      state_d = state_q;
      a_d = a_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      shl_d = shl_q;
      s_d = s_q;
      fix_d = fix_q;
      flg_d = flg_q;
      busy_d = busy_q;
      done_d = 1'b0;
      result_d = result_q;
      out_d = out_q;
      unique case (state_q)
         IDLE: if (start) begin
            a_d = a;
            busy_d = 1'b1;
            state_d = UNPACK;
         end
         UNPACK: begin
            s_d = u_s;
            shl_d = u_shl;
            cnt_d = u_n;
            fix_d = u_nan | u_inf | u_ovf | u_min | u_small;
            flg_d = {u_nan, u_inf & !u_s, u_inf & u_s, u_nan | u_ovf};
            acc_d = (u_nan | u_small) ? '0 :
                    (u_inf | u_ovf | u_min) ? (u_s ? INT_MIN : INT_MAX) : INT_W'(u_mant);
            state_d = (fix_d || u_n == '0) ? PACK : SHIFT;
         end
         SHIFT: begin
            acc_d = shl_q ? acc_q << 1 : acc_q >> 1;
            cnt_d = cnt_q - 5'd1;
            state_d = cnt_q == 5'd1 ? PACK : SHIFT;
         end
         PACK: begin
            result_d = fix_q ? acc_q : s_q ? -mag : mag;
            out_d = flg_q;
            done_d = 1'b1;
            busy_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and output registers; reset aborts any conversion in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         shl_q <= 1'b0;
         s_q <= 1'b0;
         fix_q <= 1'b0;
         flg_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         result_q <= '0;
         out_q <= '0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         shl_q <= shl_d;
         s_q <= s_d;
         fix_q <= fix_d;
         flg_q <= flg_d;
         busy_q <= busy_d;
         done_q <= done_d;
         result_q <= result_d;
         out_q <= out_d;
      end
   end
endmodule

// File: tb/tb_fp_to_int_converter.sv
// tb_fp_to_int_converter: directed and randomized checks against a real-arithmetic reference model
module tb_fp_to_int_converter;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [31:0] a = '0;
   logic        busy, done, NAN, INF, NEG_INF, ERR;
   logic [31:0] result;
   int          pass_cnt = 0, tot = 0;

   fp_to_int_converter dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .busy(busy), .done(done),
      .result(result), .NAN(NAN), .INF(INF), .NEG_INF(NEG_INF), .ERR(ERR)
   );

   always #5 clk = ~clk;

   // directed vectors; flags are {NAN, INF, NEG_INF, ERR}
   logic [31:0] dv_a [12] = '{32'h43663BE7, 32'hC728F8E0, 32'h7F800000, 32'hFF800000,
                              32'h7F800002, 32'h4F000000, 32'hCF000000, 32'h4EFFFFFF,
                              32'h3F400000, 32'h40200000, 32'h00000000, 32'hBF400000};
   logic [3:0]  dv_f [12] = '{4'b0000, 4'b0000, 4'b0100, 4'b0010, 4'b1001, 4'b0001,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`ifdef FP2INT_ROUND_NEAREST_EN
   logic [31:0] dv_r [12] = '{32'h000000E6, 32'hFFFF5707, 32'h7FFFFFFF, 32'h80000000,
                              32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFF80,
                              32'h00000001, 32'h00000002, 32'h00000000, 32'hFFFFFFFF};
   int          dv_l [12] = '{18, 10, 2, 2, 2, 2, 2, 9, 26, 24, 2, 26};
`else
   logic [31:0] dv_r [12] = '{32'h000000E6, 32'hFFFF5708, 32'h7FFFFFFF, 32'h80000000,
                              32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFF80,
                              32'h00000000, 32'h00000002, 32'h00000000, 32'h00000000};
   int          dv_l [12] = '{18, 10, 2, 2, 2, 2, 2, 9, 2, 24, 2, 2};
`endif

   // reference: value = mant * 2^(E-23), then truncate or round-half-even, then saturate
   function automatic void model(input logic [31:0] x, output logic [31:0] r,
                                 output logic [3:0] fl, output int lat);
      int  e, ex;
      real m, t;
      e = int'(x[30:23]);
      ex = e - 127;
      fl = 4'b0000;
      r = '0;
      lat = 2;
      if (e == 255) begin
         fl = x[22:0] != 0 ? 4'b1001 : x[31] ? 4'b0010 : 4'b0100;
         r = x[22:0] != 0 ? 32'h0 : x[31] ? 32'h80000000 : 32'h7FFFFFFF;
         return;
      end
      m = real'(int'({e != 0, x[22:0]})) * (2.0 ** (ex - 23));
      if (m > 2147483648.0 || (m == 2147483648.0 && !x[31])) begin
         fl = 4'b0001;
         r = x[31] ? 32'h80000000 : 32'h7FFFFFFF;
         return;
      end
      t = $floor(m);
`ifdef FP2INT_ROUND_NEAREST_EN
      if (m - t > 0.5 || (m - t == 0.5 && longint'(t) % 2 == 1)) t = t + 1.0;
      if (ex == -1) lat = 26;
`endif
      if (ex >= 0 && ex <= 30) lat = 2 + (ex >= 23 ? ex - 23 : 23 - ex);
      r = 32'(x[31] ? -longint'(t) : longint'(t));
   endfunction

   // drive one conversion and report what the DUT produced and after how many edges
   task automatic run(input logic [31:0] x, output logic [31:0] r, output logic [3:0] fl,
                      output int lat);
      @(negedge clk);
      a = x;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      r = result;
      fl = {NAN, INF, NEG_INF, ERR};
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      tot++; if ({busy, done} !== 2'b00) $display("FAIL reset_hs got %b want 00", {busy, done}); else pass_cnt++;
      tot++; if (result !== 32'h0) $display("FAIL reset_result got %h want 0", result); else pass_cnt++;
      tot++; if ({NAN, INF, NEG_INF, ERR} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {NAN, INF, NEG_INF, ERR}); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] r;
      logic [3:0]  fl;
      int          lat;
      for (int i = 0; i < 12; i++) begin
         run(dv_a[i], r, fl, lat);
         tot++; if (r !== dv_r[i]) $display("FAIL dir%0d_result a=%h got %h want %h", i, dv_a[i], r, dv_r[i]); else pass_cnt++;
         tot++; if (fl !== dv_f[i]) $display("FAIL dir%0d_flags a=%h got %b want %b", i, dv_a[i], fl, dv_f[i]); else pass_cnt++;
         tot++; if (lat !== dv_l[i]) $display("FAIL dir%0d_latency a=%h got %0d want %0d", i, dv_a[i], lat, dv_l[i]); else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [31:0] x, r, er;
      logic [3:0]  fl, ef;
      logic [7:0]  e8;
      int          lat, el, sel;
      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 19));
         e8 = sel == 0 ? 8'hFF : sel == 1 ? 8'h00 : 8'($urandom_range(118, 160));
         x = {1'($urandom_range(0, 1)), e8, 23'($urandom)};
         if (sel == 2) x[22:0] = '0;
         model(x, er, ef, el);
         run(x, r, fl, lat);
         tot++; if (r !== er) $display("FAIL rnd%0d_result a=%h got %h want %h", i, x, r, er); else pass_cnt++;
         tot++; if (fl !== ef) $display("FAIL rnd%0d_flags a=%h got %b want %b", i, x, fl, ef); else pass_cnt++;
         tot++; if (lat !== el) $display("FAIL rnd%0d_latency a=%h got %0d want %0d", i, x, lat, el); else pass_cnt++;
      end
   endtask

   task automatic test_start_while_busy();
      int          dones = 0;
      logic [31:0] last = '0;
      @(negedge clk);
      a = 32'h43663BE7;
      start = 1'b1;
      @(posedge clk);
      #1;
      tot++; if (busy !== 1'b1) $display("FAIL busy_after_accept got %b want 1", busy); else pass_cnt++;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      a = 32'h40200000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            dones++;
            last = result;
         end
      end
      tot++; if (dones !== 1) $display("FAIL busy_start_dones got %0d want 1", dones); else pass_cnt++;
      tot++; if (last !== 32'hE6) $display("FAIL busy_start_result got %h want 000000e6", last); else pass_cnt++;
      tot++; if (busy !== 1'b0) $display("FAIL busy_after_done got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int idx [$];
      @(negedge clk);
      a = 32'h7F800000;
      start = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 9; i++) begin
         @(posedge clk);
         #1;
         if (done) idx.push_back(i);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      tot++; if (idx.size() < 2 || idx[0] !== 2 || idx[1] !== 5) $display("FAIL b2b_done_edges got %p want 2,5,...", idx); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      logic [3:0]  fl;
      int          lat, dones = 0;
      run(32'hFF800000, r, fl, lat);
      @(negedge clk);
      a = 32'h43663BE7;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      tot++; if ({busy, done} !== 2'b00) $display("FAIL midrst_hs got %b want 00", {busy, done}); else pass_cnt++;
      tot++; if (result !== 32'h0) $display("FAIL midrst_result got %h want 0", result); else pass_cnt++;
      tot++; if ({NAN, INF, NEG_INF, ERR} !== 4'b0) $display("FAIL midrst_flags got %b want 0000", {NAN, INF, NEG_INF, ERR}); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      tot++; if (dones !== 0) $display("FAIL midrst_no_done got %0d want 0", dones); else pass_cnt++;
      run(32'h00000000, r, fl, lat);
      tot++; if (r !== 32'h0) $display("FAIL zero_result got %h want 0", r); else pass_cnt++;
      tot++; if (lat !== 2) $display("FAIL zero_latency got %0d want 2", lat); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot);
      $finish;
   end
endmodule
